// File: rtl/mod_counter_ctrl.sv
// Mod-N up-counter sequencer: start/stop/clear, programmable modulus,
// one-shot or free-run, terminal-count strobe and saturating wrap count.
module mod_counter_ctrl #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_MOD = 14,
  parameter int WRAPW       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             oneshot,
  input  logic [WIDTH:0]   mod_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [WRAPW-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [WIDTH:0] MOD_MIN = (WIDTH+1)'(2);
  localparam logic [WIDTH:0] MOD_MAX = (WIDTH+1)'(2**WIDTH);
  localparam logic [WIDTH:0] MOD_DEF = (WIDTH+1)'(DEFAULT_MOD);

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n;
  logic [WRAPW-1:0] wrap_n;
  logic [WIDTH:0]   mod_r, mod_n;
  logic             mode_r, mode_n;
  logic             mod_ok;

  assign mod_ok = (mod_val >= MOD_MIN) && (mod_val <= MOD_MAX);

  // Compare in WIDTH+1 bits so a full 2^WIDTH modulus hits tc at all-ones.
  assign tc   = (state == RUN) && ({1'b0, q} == mod_r - 1'b1);
  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

  always_comb begin
    state_n = state;
    q_n     = q;
    wrap_n  = wrap_cnt;
    mod_n   = mod_r;
    mode_n  = mode_r;
    if (clear) begin
      state_n = IDLE;
      q_n     = '0;
      wrap_n  = '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state_n = RUN;
            q_n     = '0;
            wrap_n  = '0;
            mod_n   = mod_ok ? mod_val : MOD_DEF;
            mode_n  = oneshot;
          end
        end
        RUN: begin
          if (stop) begin
            state_n = PAUSE;
          end else if (tc) begin
            q_n = '0;
            if (mode_r) begin
              state_n = DONE;
            end else if (wrap_cnt != '1) begin
              wrap_n = wrap_cnt + 1'b1;
            end
          end else begin
            q_n = q + 1'b1;
          end
        end
        PAUSE: begin
          if (start) state_n = RUN;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      q        <= '0;
      wrap_cnt <= '0;
      mod_r    <= MOD_DEF;
      mode_r   <= 1'b0;
    end else begin
      state    <= state_n;
      q        <= q_n;
      wrap_cnt <= wrap_n;
      mod_r    <= mod_n;
      mode_r   <= mode_n;
    end
  end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed bench for mod_counter_ctrl: vector table plus
// hand-written multi-cycle sequences.
module tb_mod_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, clear, oneshot;
  logic [4:0] mod_val;
  logic [3:0] q;
  logic       tc, busy, done;
  logic [7:0] wrap_cnt;

  int checks = 0;
  int errors = 0;

  mod_counter_ctrl #(
    .WIDTH(4),
    .DEFAULT_MOD(14),
    .WRAPW(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .clear(clear),
    .oneshot(oneshot),
    .mod_val(mod_val),
    .q(q),
    .tc(tc),
    .busy(busy),
    .done(done),
    .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s, p, c, o;
    logic [4:0] m;
    int         q, tc, busy, done, wrap;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int eq, input int etc,
                         input int eb, input int ed, input int ew);
    chk({tag, ".q"}, int'(q), eq);
    chk({tag, ".tc"}, int'(tc), etc);
    chk({tag, ".busy"}, int'(busy), eb);
    chk({tag, ".done"}, int'(done), ed);
    chk({tag, ".wrap"}, int'(wrap_cnt), ew);
  endtask

  task automatic step(input logic s, input logic p, input logic c,
                      input logic o, input logic [4:0] m);
    start = s; stop = p; clear = c; oneshot = o; mod_val = m;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  function automatic vec_t v(input logic s, input logic p, input logic c,
                             input logic o, input logic [4:0] m,
                             input int eq, input int et, input int eb,
                             input int ed, input int ew);
    vec_t r;
    r.s = s; r.p = p; r.c = c; r.o = o; r.m = m;
    r.q = eq; r.tc = et; r.busy = eb; r.done = ed; r.wrap = ew;
    return r;
  endfunction

  initial begin
    // one-shot mod 5
    tbl[0]  = v(1,0,0,1,5'd5,  0,0,1,0,0);
    tbl[1]  = v(0,0,0,0,5'd0,  1,0,1,0,0);
    tbl[2]  = v(0,0,0,0,5'd0,  2,0,1,0,0);
    tbl[3]  = v(0,0,0,0,5'd0,  3,0,1,0,0);
    tbl[4]  = v(0,0,0,0,5'd0,  4,1,1,0,0);
    tbl[5]  = v(0,0,0,0,5'd0,  0,0,0,1,0);
    tbl[6]  = v(0,0,0,0,5'd0,  0,0,0,1,0);
    // restart free-run mod 3 from DONE
    tbl[7]  = v(1,0,0,0,5'd3,  0,0,1,0,0);
    tbl[8]  = v(0,0,0,0,5'd0,  1,0,1,0,0);
    tbl[9]  = v(0,0,0,0,5'd0,  2,1,1,0,0);
    tbl[10] = v(0,0,0,0,5'd0,  0,0,1,0,1);
    tbl[11] = v(0,0,0,0,5'd0,  1,0,1,0,1);
    // stop+start in RUN pauses; stop in PAUSE ignored
    tbl[12] = v(1,1,0,0,5'd0,  1,0,1,0,1);
    tbl[13] = v(0,1,0,0,5'd0,  1,0,1,0,1);
    tbl[14] = v(1,0,0,0,5'd9,  1,0,1,0,1);
    tbl[15] = v(0,0,0,0,5'd0,  2,1,1,0,1);
    // stop on the tc edge suppresses wrap
    tbl[16] = v(0,1,0,0,5'd0,  2,0,1,0,1);
    tbl[17] = v(1,0,0,0,5'd0,  2,1,1,0,1);
    tbl[18] = v(1,0,0,1,5'd7,  0,0,1,0,2);
    // clear+start wins clear
    tbl[19] = v(1,0,1,0,5'd0,  0,0,0,0,0);
    tbl[20] = v(0,0,0,0,5'd0,  0,0,0,0,0);
    tbl[21] = v(1,0,0,1,5'd16, 0,0,1,0,0);

    rst_n = 1'b0;
    start = 0; stop = 0; clear = 0; oneshot = 0; mod_val = '0;
    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].o, tbl[i].m);
      chk_all($sformatf("vec%0d", i), tbl[i].q, tbl[i].tc,
              tbl[i].busy, tbl[i].done, tbl[i].wrap);
    end

    // free-run mod 14 for 42 cycles
    do_reset();
    step(1,0,0,0,5'd14);
    chk_all("m14.start", 0, 0, 1, 0, 0);
    for (int k = 1; k <= 42; k++) begin
      step(0,0,0,0,5'd0);
      chk_all($sformatf("m14.k%0d", k), k % 14,
              (k % 14 == 13) ? 1 : 0, 1, 0, k / 14);
    end

    // out-of-range moduli fall back to 14
    for (int t = 0; t < 2; t++) begin
      step(0,0,1,0,5'd0);
      step(1,0,0,0, t == 0 ? 5'd1 : 5'd17);
      for (int k = 1; k <= 14; k++) begin
        step(0,0,0,0,5'd0);
        chk($sformatf("bad%0d.q%0d", t, k), int'(q), k % 14);
        chk($sformatf("bad%0d.tc%0d", t, k), int'(tc),
            (k == 13) ? 1 : 0);
      end
    end

    // full-range modulus 16
    step(0,0,1,0,5'd0);
    step(1,0,0,0,5'd16);
    for (int k = 1; k <= 16; k++) begin
      step(0,0,0,0,5'd0);
      chk_all($sformatf("m16.k%0d", k), k % 16,
              (k == 15) ? 1 : 0, 1, 0, k / 16);
    end

    // pause at 6 for 3 cycles, resume, start in RUN ignored
    step(0,0,1,0,5'd0);
    step(1,0,0,0,5'd14);
    for (int k = 1; k <= 6; k++) step(0,0,0,0,5'd0);
    chk("pz.q6", int'(q), 6);
    for (int k = 0; k < 3; k++) begin
      step(0,1,0,0,5'd0);
      chk($sformatf("pz.hold%0d", k), int'(q), 6);
      chk($sformatf("pz.busy%0d", k), int'(busy), 1);
    end
    step(1,0,0,0,5'd3);
    chk("pz.res", int'(q), 6);
    step(0,0,0,0,5'd0);
    chk("pz.q7", int'(q), 7);
    step(1,0,0,1,5'd3);
    chk("pz.q8", int'(q), 8);
    step(0,0,0,0,5'd0);
    chk("pz.q9", int'(q), 9);
    // clear+start at q=9
    step(1,0,1,0,5'd0);
    chk_all("clr", 0, 0, 0, 0, 0);

    // async reset mid-cycle at q=10, wrap=2
    step(1,0,0,0,5'd14);
    for (int k = 1; k <= 38; k++) step(0,0,0,0,5'd0);
    chk("ar.pre.q", int'(q), 10);
    chk("ar.pre.wrap", int'(wrap_cnt), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("ar.async", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(0,0,0,0,5'd0);
      chk_all($sformatf("ar.idle%0d", k), 0, 0, 0, 0, 0);
    end
    step(1,0,0,0,5'd14);
    step(0,0,0,0,5'd0);
    chk_all("ar.run", 1, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter_ctrl.md
Name: mod_counter_ctrl

Overview:
Sequencing controller for the team's mod-N up-counters. It owns a WIDTH-bit count register and provides start/stop/clear commands, a runtime-programmable modulus, one-shot and free-run modes, a terminal-count strobe and a saturating wrap counter. The modulus is detected synchronously, so there is no glitch-driven asynchronous self-reset. It sits between a host/sequencer and any logic that needs timed count windows; DEFAULT_MOD=14 reproduces the existing mod-14 behaviour.

Parameters:
WIDTH, 4, count register width; legal modulus range is 2..2^WIDTH
DEFAULT_MOD, 14, modulus used when mod_val is out of range; must itself be in 2..2^WIDTH
WRAPW, 8, width of saturating wrap counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level sampled each edge; begin/resume/restart counting
stop  in  1  pause counting (RUN only)
clear  in  1  return to IDLE, zero all state
oneshot  in  1  sampled with start from IDLE/DONE; 1 = stop after one period, 0 = free-run
mod_val  in  WIDTH+1  requested modulus, sampled with start from IDLE/DONE
q  out  WIDTH  current count
tc  out  1  terminal count: high while state==RUN and q==mod_r-1 (combinational from registers)
busy  out  1  high in RUN and PAUSE
done  out  1  high in DONE
wrap_cnt  out  WRAPW  number of free-run wraps since last start from IDLE/DONE, saturating

Behaviour:
- Reset (rst_n=0, async, any time incl. mid-count): state=IDLE, q=0, mod_r=DEFAULT_MOD, mode_r=0, wrap_cnt=0; hence tc=0, busy=0, done=0.
- States: IDLE, RUN, PAUSE, DONE. Command priority per edge: clear > stop > start.
- clear (any state): next state IDLE, q=0, wrap_cnt=0; mod_r/mode_r retained.
- IDLE/DONE + start: latch mod_r (mod_val if 2<=mod_val<=2^WIDTH, else DEFAULT_MOD) and mode_r=oneshot; q=0; wrap_cnt=0; next state RUN.
- RUN, no stop/clear: if q!=mod_r-1 then q<=q+1; else (tc) q<=0 and:
  - mode_r=1: next state DONE.
  - mode_r=0: stay RUN; wrap_cnt<=wrap_cnt+1, holds at 2^WRAPW-1.
- RUN + stop: next state PAUSE, q held (the tc-edge increment/wrap does not occur). start while RUN: ignored.
- PAUSE: q and wrap_cnt held; start resumes RUN without relatching mod_r/mode_r; stop ignored.
- DONE: q=0, held until start or clear; stop ignored.
- Timing: start sampled at edge E0 gives q=0 after E0 and q=k after E0+k. In one-shot mode tc is high between E(mod_r-1) and E(mod_r), and done is asserted after E(mod_r).
- mod_r=2^WIDTH: q covers the full range; the wrap is the natural rollover to 0.
- mod_val and oneshot are ignored except when start is accepted from IDLE/DONE; changing them mid-run has no effect.
- Simultaneous stop+start in RUN: PAUSE. Simultaneous clear+start: IDLE.

Test Plan:
- Reset, start with mod_val=14, oneshot=0 -> q counts 0..13, tc high only at q=13, q=0 next; wrap_cnt=1 after first wrap, 3 after 42 cycles.
- start with mod_val=5, oneshot=1 -> q 0,1,2,3,4, tc at q=4, done=1 and busy=0 from 5th edge, q stays 0; then start -> restarts at 0, done=0.
- Free-run mod 14; stop at q=6 for 3 cycles -> q holds 6, busy=1; start -> continues 7,8,...; start asserted while RUN -> no effect.
- mod_val=1 then mod_val=17 -> both count with modulus 14 (tc at 13); mod_val=16 -> full 0..15 with tc at 15.
- Simultaneous clear+start at q=9 -> IDLE, q=0, wrap_cnt=0, busy=0; simultaneous stop+start in RUN -> PAUSE.
- rst_n pulsed low mid-cycle at q=10 with wrap_cnt=2 -> outputs zero immediately without a clock edge; after release, start is required to count again.
